// File: rtl/fetch_unit.sv
// Instruction fetch unit: requests one instruction word at pc, holds it for the
// controller while it executes, then advances pc by sequential, branch or jump rules.
module fetch_unit (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic        imem_ack,
   input  logic [15:0] imem_rdata,
   output logic [15:0] instr,
   output logic [3:0]  opcode,
   output logic        instr_valid,
   output logic [15:0] pc,
   input  logic        pcsrc,
   input  logic        jump,
   input  logic [15:0] signimm,
   input  logic        stall,
   output logic        fetch_err
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      REQ  = 2'b01,
      EXEC = 2'b10,
      HALT = 2'b11
   } state_t;

   localparam logic [3:0] WAIT_LIMIT = 4'd15;

   state_t      state, state_nxt;
   logic [3:0]  wait_cnt, wait_cnt_nxt;
   logic [15:0] pc_nxt, instr_nxt;
   logic        fetch_err_nxt;

   logic [15:0] pc_plus2;
   logic [15:0] branch_target;
   logic [15:0] jump_target;
   logic [15:0] next_pc;

   // Branch offsets count instruction words, so they are doubled into bytes.
   assign pc_plus2      = pc + 16'd2;
   assign branch_target = pc_plus2 + (signimm << 1);
   assign jump_target   = {pc_plus2[15:13], instr[11:0], 1'b0};

   always_comb begin
      if (jump)
         next_pc = jump_target;
      else if (pcsrc)
         next_pc = branch_target;
      else
         next_pc = pc_plus2;
   end

   // NOTE: every variable gets its hold value first so no path leaves one
   // unassigned; that is what keeps this block from inferring latches.
   always_comb begin
      state_nxt     = state;
      wait_cnt_nxt  = wait_cnt;
      pc_nxt        = pc;
      instr_nxt     = instr;
      fetch_err_nxt = fetch_err;

      case (state)
         IDLE: begin
            state_nxt    = REQ;
            wait_cnt_nxt = 4'd0;
         end

         REQ: begin
            // An ack on the last permitted cycle still wins over the timeout.
            if (imem_ack) begin
               instr_nxt = imem_rdata;
               state_nxt = EXEC;
            end else if (wait_cnt == WAIT_LIMIT) begin
               state_nxt     = HALT;
               fetch_err_nxt = 1'b1;
            end else begin
               wait_cnt_nxt = wait_cnt + 4'd1;
            end
         end

         EXEC: begin
            if (!stall) begin
               pc_nxt       = next_pc;
               state_nxt    = REQ;
               wait_cnt_nxt = 4'd0;
            end
         end

         HALT: begin
            state_nxt = HALT;
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the values from before this edge, regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         wait_cnt  <= 4'd0;
         pc        <= 16'h0000;
         instr     <= 16'h0000;
         fetch_err <= 1'b0;
      end else begin
         state     <= state_nxt;
         wait_cnt  <= wait_cnt_nxt;
         pc        <= pc_nxt;
         instr     <= instr_nxt;
         fetch_err <= fetch_err_nxt;
      end
   end

   assign imem_req    = (state == REQ);
   assign instr_valid = (state == EXEC);
   assign imem_addr   = pc;
   assign opcode      = instr[15:12];

endmodule
